// File: rtl/aes_iter_core_v2.sv
// aes_iter_core_v2: iterative AES round engine, one round per clock.
// Handles AES-128/192/256 encrypt (forward cipher) or decrypt (equivalent
// inverse cipher). Round keys come from an external key store. A small
// output FIFO decouples the round datapath from the consumer.
//
// Optional macro AES_CBC_CHAIN_EN adds a CBC chaining register and the
// ports in_chain, iv_load and iv_data.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready/in_data   input block handshake and payload
//   in_op, in_keylen, in_tag    1=encrypt/0=decrypt, key size, user tag
//   key_req/key_addr            round-key fetch request and index
//   key_valid/key_data          round key returned by the key store
//   out_valid/out_ready         output FIFO head handshake
//   out_data/out_tag/out_op     result block, its tag and op
//   busy                        block in flight in the round datapath
//   err_keylen                  sticky illegal-keylen flag
module aes_iter_core_v2 #(
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned OUT_DEPTH = 2,
    parameter int unsigned KEY_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_data,
    input  logic                 in_op,
    input  logic [1:0]           in_keylen,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 key_req,
    output logic [KEY_IDX_W-1:0] key_addr,
    input  logic                 key_valid,
    input  logic [127:0]         key_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_op,
    output logic                 busy,
    output logic                 err_keylen
`ifdef AES_CBC_CHAIN_EN
    ,
    input  logic                 in_chain,
    input  logic                 iv_load,
    input  logic [127:0]         iv_data
`endif
);

    localparam int unsigned PTR_W  = $clog2(OUT_DEPTH);
    localparam int unsigned CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int unsigned STEP_W = 4;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} st_t;

    // ---------------- GF(2^8) helpers and round transforms ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = inv ? inv_sbox(s[8*k +: 8]) : sbox(s[8*k +: 8]);
        return r;
    endfunction

    // Byte b = 4*col + row sits at bits [127-8b -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*src -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3, m0, m1, m2, m3;
        m0 = inv ? 8'h0e : 8'h02;
        m1 = inv ? 8'h0b : 8'h03;
        m2 = inv ? 8'h0d : 8'h01;
        m3 = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, m0) ^ gmul(a1, m1) ^ gmul(a2, m2) ^ gmul(a3, m3);
            o[119 - 32*c -: 8] = gmul(a0, m3) ^ gmul(a1, m0) ^ gmul(a2, m1) ^ gmul(a3, m2);
            o[111 - 32*c -: 8] = gmul(a0, m2) ^ gmul(a1, m3) ^ gmul(a2, m0) ^ gmul(a3, m1);
            o[103 - 32*c -: 8] = gmul(a0, m1) ^ gmul(a1, m2) ^ gmul(a2, m3) ^ gmul(a3, m0);
        end
        return o;
    endfunction

    // ---------------- state ----------------
    st_t                 st_q, st_d;
    logic [127:0]        state_q;
    logic                op_q;
    logic [TAG_W-1:0]    tag_q;
    logic [STEP_W-1:0]   nr_q, step_q, nr_in;
    logic                accept, consume, last, pop;
    logic [127:0]        sb, sr, mc, rnd, res;

    logic [127:0]        fifo_data [OUT_DEPTH];
    logic [TAG_W-1:0]    fifo_tag  [OUT_DEPTH];
    logic                fifo_op   [OUT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;

`ifdef AES_CBC_CHAIN_EN
    logic [127:0]        chain_q, ct_q;
    logic                chain_on_q;
`endif

    assign busy      = (st_q == ST_RUN);
    assign key_req   = busy;
    assign in_ready  = (st_q == ST_IDLE) && (count < CNT_W'(OUT_DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_tag   = fifo_tag[rd_ptr];
    assign out_op    = fifo_op[rd_ptr];
    assign pop       = out_valid && out_ready;

    // Illegal keylen falls back to ten rounds.
    always_comb begin
        case (in_keylen)
            2'b01:   nr_in = 4'd12;
            2'b10:   nr_in = 4'd14;
            default: nr_in = 4'd10;
        endcase
    end

    // Control FSM: next state and per-cycle strobes.
    always_comb begin
        st_d    = st_q;
        accept  = 1'b0;
        consume = 1'b0;
        last    = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    st_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (key_valid) begin
                    consume = 1'b1;
                    if (step_q == nr_q) begin
                        last = 1'b1;
                        st_d = ST_IDLE;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) st_q <= ST_IDLE;
        else        st_q <= st_d;
    end

    // Round datapath: step 0 is key whitening, last step skips (Inv)MixColumns.
    always_comb begin
        sb = sub_bytes(state_q, !op_q);
        sr = shift_rows(sb, !op_q);
        mc = mix_columns(sr, !op_q);
        if (step_q == '0)        rnd = state_q ^ key_data;
        else if (step_q == nr_q) rnd = sr ^ key_data;
        else                     rnd = mc ^ key_data;
        res = rnd;
`ifdef AES_CBC_CHAIN_EN
        if (chain_on_q && !op_q) res = rnd ^ chain_q;
`endif
    end

    // Block registers, key addressing and output FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= '0;
            op_q       <= 1'b0;
            tag_q      <= '0;
            nr_q       <= '0;
            step_q     <= '0;
            key_addr   <= '0;
            err_keylen <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= '0;
                fifo_op[i]   <= 1'b0;
            end
        end else begin
            if (accept) begin
                state_q  <= in_data;
`ifdef AES_CBC_CHAIN_EN
                if (in_chain && in_op) state_q <= in_data ^ chain_q;
`endif
                op_q     <= in_op;
                tag_q    <= in_tag;
                nr_q     <= nr_in;
                step_q   <= '0;
                key_addr <= in_op ? '0 : KEY_IDX_W'(nr_in);
                if (in_keylen == 2'b11) err_keylen <= 1'b1;
            end else if (consume) begin
                state_q <= rnd;
                step_q  <= step_q + 4'd1;
                if (last)      key_addr <= '0;
                else if (op_q) key_addr <= key_addr + 1'b1;
                else           key_addr <= key_addr - 1'b1;
            end
            if (last) begin
                fifo_data[wr_ptr] <= res;
                fifo_tag[wr_ptr]  <= tag_q;
                fifo_op[wr_ptr]   <= op_q;
                wr_ptr            <= PTR_W'(wr_ptr + 1'b1);
            end
            if (pop) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            count <= count + CNT_W'(last) - CNT_W'(pop);
        end
    end

`ifdef AES_CBC_CHAIN_EN
    // CBC chain: IV load while idle; updated with the block's chaining value at push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q    <= '0;
            ct_q       <= '0;
            chain_on_q <= 1'b0;
        end else begin
            if (accept) begin
                chain_on_q <= in_chain;
                ct_q       <= in_data;
            end
            if (!busy && iv_load)      chain_q <= iv_data;
            else if (last && chain_on_q) chain_q <= op_q ? rnd : ct_q;
        end
    end
`endif

endmodule

// File: tb/tb_aes_iter_core_v2.sv
// Directed bench for aes_iter_core_v2: FIPS-197 vectors in a table, key
// stalls, output backpressure, illegal keylen and mid-block reset.
// Build with AES_CBC_CHAIN_EN to also exercise CBC chaining.
module tb_aes_iter_core_v2;

    localparam int unsigned TAG_W = 8;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_op, key_req, key_valid;
    logic out_valid, out_ready, out_op, busy, err_keylen;
    logic [127:0] in_data, key_data, out_data;
    logic [1:0]   in_keylen;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [3:0]   key_addr;
`ifdef AES_CBC_CHAIN_EN
    logic in_chain, iv_load;
    logic [127:0] iv_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] ks [16];
    logic [7:0]   mon_tag [$];
    logic [127:0] mon_data [$];

    always #5 clk = ~clk;

    aes_iter_core_v2 #(.TAG_W(TAG_W), .OUT_DEPTH(2), .KEY_IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_op(in_op), .in_keylen(in_keylen), .in_tag(in_tag),
        .key_req(key_req), .key_addr(key_addr), .key_valid(key_valid), .key_data(key_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_op(out_op), .busy(busy), .err_keylen(err_keylen)
`ifdef AES_CBC_CHAIN_EN
        , .in_chain(in_chain), .iv_load(iv_load), .iv_data(iv_data)
`endif
    );

    // Key store model: returns garbage when key_valid is low.
    always_comb key_data = key_valid ? ks[key_addr] : 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    // Pop monitor: the head is captured at the negedge before the popping edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_tag.push_back(out_tag);
            mon_data.push_back(out_data);
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box built by walking generator 3 and its inverse in lockstep.
    task automatic init_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] imc(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
            o[119-32*c -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
            o[111-32*c -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
            o[103-32*c -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
        end
        return o;
    endfunction

    // FIPS-197 key expansion into the key store; decrypt middle keys get InvMixColumns.
    task automatic load_keys(input logic [255:0] key, input int nk, input logic dec);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [127:0] rk;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) ks[r] = 128'h0;
        for (int r = 0; r <= nr; r++) begin
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            if (dec && r != 0 && r != nr) rk = imc(rk);
            ks[r] = rk;
        end
    endtask

    // Present a block until accepted (bounded); afterwards junk the inputs.
    task automatic offer(input logic [127:0] d, input logic op, input logic [1:0] kl,
                         input logic [7:0] tag, input int budget, output logic ok);
        int g;
        in_valid = 1'b1; in_data = d; in_op = op; in_keylen = kl; in_tag = tag;
        g = 0;
        while (!in_ready && g < budget) begin
            @(posedge clk); #1; g++;
        end
        ok = in_ready;
        if (ok) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_data = ~d; in_op = ~op; in_keylen = ~kl; in_tag = ~tag;
    endtask

    // Run one block; lat = edges from accept to out_valid (-1 on timeout).
    task automatic run_block(input logic [127:0] d, input logic op, input logic [1:0] kl,
                             input logic [7:0] tag, input int nr, input int stall_pct,
                             output int lat, output int aerr, output int stalls);
        logic ok;
        int idx;
        lat = 0; aerr = 0; stalls = 0; idx = 0;
        offer(d, op, kl, tag, 50, ok);
        if (!ok) begin
            lat = -1;
            return;
        end
        while (!out_valid && lat < 300) begin
            if (busy) begin
                key_valid = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
                if (key_addr !== 4'(op ? idx : nr - idx)) aerr++;
                if (key_valid) idx++;
                else stalls++;
            end
            @(posedge clk); #1; lat++;
        end
        key_valid = 1'b1;
        if (!out_valid) lat = -1;
        if (idx != nr + 1) aerr++;
    endtask

    typedef struct {
        logic [255:0] key;
        int           nk;
        logic [1:0]   kl;
        logic         op;
        logic [127:0] din;
        logic [127:0] dout;
        logic [7:0]   tag;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, aerr, stalls, g, n0;
        logic ok, blocked;

        vecs[0] = '{K128, 4, 2'b00, 1'b1, PT, CT128, 8'h11};
        vecs[1] = '{K192, 6, 2'b01, 1'b1, PT, CT192, 8'h12};
        vecs[2] = '{K256, 8, 2'b10, 1'b1, PT, CT256, 8'h13};
        vecs[3] = '{K128, 4, 2'b00, 1'b0, CT128, PT, 8'h14};
        vecs[4] = '{K192, 6, 2'b01, 1'b0, CT192, PT, 8'h15};
        vecs[5] = '{K256, 8, 2'b10, 1'b0, CT256, PT, 8'h16};
        vecs[6] = '{K128, 4, 2'b11, 1'b1, PT, CT128, 8'h17};

        init_sbox();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = 1'b0; in_keylen = 2'b00;
        in_tag = '0; key_valid = 1'b1; out_ready = 1'b1;
`ifdef AES_CBC_CHAIN_EN
        in_chain = 1'b0; iv_load = 1'b0; iv_data = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_key_req", 128'(key_req), 128'd0);
        check("rst_key_addr", 128'(key_addr), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_tag", 128'(out_tag), 128'd0);
        check("rst_out_op", 128'(out_op), 128'd0);
        check("rst_err_keylen", 128'(err_keylen), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of FIPS-197 vectors, encrypt and decrypt, plus illegal keylen.
        for (int v = 0; v < 7; v++) begin
            load_keys(vecs[v].key, vecs[v].nk, !vecs[v].op);
            run_block(vecs[v].din, vecs[v].op, vecs[v].kl, vecs[v].tag, vecs[v].nk + 6, 0,
                      lat, aerr, stalls);
            check($sformatf("vec%0d_latency", v), 128'(lat), 128'(vecs[v].nk + 7));
            check($sformatf("vec%0d_data", v), out_data, vecs[v].dout);
            check($sformatf("vec%0d_tag", v), 128'(out_tag), 128'(vecs[v].tag));
            check($sformatf("vec%0d_op", v), 128'(out_op), 128'(vecs[v].op));
            check($sformatf("vec%0d_key_addr_seq", v), 128'(aerr), 128'd0);
            @(posedge clk); #1;
        end
        check("err_keylen_set", 128'(err_keylen), 128'd1);

        // Random key stalls during AES-128 encrypt.
        load_keys(K128, 4, 1'b0);
        run_block(PT, 1'b1, 2'b00, 8'h21, 10, 30, lat, aerr, stalls);
        check("stall_data", out_data, CT128);
        check("stall_latency", 128'(lat), 128'(11 + stalls));
        check("stall_key_addr_hold", 128'(aerr), 128'd0);
        check("err_keylen_sticky", 128'(err_keylen), 128'd1);
        @(posedge clk); #1;

        // Backpressure: two results fill the FIFO, third block must wait.
        out_ready = 1'b0;
        offer(PT, 1'b1, 2'b00, 8'h01, 50, ok);
        check("bp_accept1", 128'(ok), 128'd1);
        offer(PT, 1'b1, 2'b00, 8'h02, 50, ok);
        check("bp_accept2", 128'(ok), 128'd1);
        g = 0;
        while (busy && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("bp_second_done", 128'(busy), 128'd0);
        in_valid = 1'b1; in_data = PT; in_op = 1'b1; in_keylen = 2'b00; in_tag = 8'h03;
        blocked = 1'b1;
        repeat (20) begin
            if (in_ready) blocked = 1'b0;
            @(posedge clk); #1;
        end
        check("bp_in_ready_low", 128'(blocked), 128'd1);
        check("bp_third_not_taken", 128'(busy), 128'd0);
        check("bp_head_tag", 128'(out_tag), 128'h01);
        n0 = mon_tag.size();
        out_ready = 1'b1;
        offer(PT, 1'b1, 2'b00, 8'h03, 50, ok);
        check("bp_accept3", 128'(ok), 128'd1);
        g = 0;
        while (mon_tag.size() < n0 + 3 && g < 100) begin
            @(posedge clk); #1; g++;
        end
        check("bp_drain_count", 128'(mon_tag.size()), 128'(n0 + 3));
        for (int i = 0; i < 3; i++) begin
            if (mon_tag.size() > n0 + i) begin
                check($sformatf("bp_drain%0d_tag", i), 128'(mon_tag[n0 + i]), 128'(i + 1));
                check($sformatf("bp_drain%0d_data", i), mon_data[n0 + i], CT128);
            end
        end

`ifdef AES_CBC_CHAIN_EN
        // CBC: SP800-38A F.2.1 first two blocks, encrypt then decrypt.
        load_keys({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 1'b0);
        iv_data = 128'h000102030405060708090a0b0c0d0e0f;
        iv_load = 1'b1; @(posedge clk); #1; iv_load = 1'b0;
        in_chain = 1'b1;
        run_block(128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 2'b00, 8'h31, 10, 0, lat, aerr, stalls);
        check("cbc_enc1", out_data, 128'h7649abac8119b246cee98e9b12e9197d);
        @(posedge clk); #1;
        run_block(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 2'b00, 8'h32, 10, 0, lat, aerr, stalls);
        check("cbc_enc2", out_data, 128'h5086cb9b507219ee95db113a917678b2);
        @(posedge clk); #1;
        load_keys({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 1'b1);
        iv_load = 1'b1; @(posedge clk); #1; iv_load = 1'b0;
        run_block(128'h7649abac8119b246cee98e9b12e9197d, 1'b0, 2'b00, 8'h33, 10, 0, lat, aerr, stalls);
        check("cbc_dec1", out_data, 128'h6bc1bee22e409f96e93d7e117393172a);
        @(posedge clk); #1;
        run_block(128'h5086cb9b507219ee95db113a917678b2, 1'b0, 2'b00, 8'h34, 10, 0, lat, aerr, stalls);
        check("cbc_dec2", out_data, 128'hae2d8a571e03ac9c9eb76fac45af8e51);
        @(posedge clk); #1;
        in_chain = 1'b0;
`endif

        // Reset in the middle of a block (after five keys consumed).
        load_keys(K128, 4, 1'b0);
        n0 = mon_tag.size();
        offer(PT, 1'b1, 2'b00, 8'h55, 50, ok);
        check("mid_accept", 128'(ok), 128'd1);
        g = 0;
        while (key_addr != 4'd5 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("mid_reached_step5", 128'(key_addr), 128'd5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_err_keylen", 128'(err_keylen), 128'd0);
        check("mid_rst_key_req", 128'(key_req), 128'd0);
        check("mid_rst_key_addr", 128'(key_addr), 128'd0);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("mid_no_output", 128'(mon_tag.size()), 128'(n0));
        check("mid_out_valid_idle", 128'(out_valid), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
